// File: rtl/nibble_seq_alu_ctrl_if.sv
// Bundle between the execute stage, the nibble sequencer and the shared 4-bit ALU.
// The slave modport is the sequencer's view; master is the surrounding system.
interface nibble_seq_alu_ctrl_if;
    logic        start;
    logic [5:0]  opcode;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cf;
    logic        zf;
    logic        illegal;
    logic [5:0]  alu_opcode;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [3:0]  alu_r;
    logic        alu_cf;

    modport slave (
        input  start, opcode, a, b, alu_r, alu_cf,
        output busy, done, result, cf, zf, illegal, alu_opcode, alu_a, alu_b
    );

    modport master (
        output start, opcode, a, b, alu_r, alu_cf,
        input  busy, done, result, cf, zf, illegal, alu_opcode, alu_a, alu_b
    );
endinterface

// File: rtl/nibble_seq_alu_ctrl.sv
// Runs 16-bit operations through the shared 4-bit combinational ALU one nibble per
// cycle, chaining carry/shift bits and adding a fix-up INC pass for ADD carries.
module nibble_seq_alu_ctrl (
    input  logic                        clk,
    input  logic                        reset,
    nibble_seq_alu_ctrl_if.slave        bus
);

    localparam logic [5:0] OP_AND_A_B = 6'h01;
    localparam logic [5:0] OP_OR_A_B  = 6'h02;
    localparam logic [5:0] OP_XOR_A_B = 6'h03;
    localparam logic [5:0] OP_NOT_A   = 6'h04;
    localparam logic [5:0] OP_ADD_A_B = 6'h05;
    localparam logic [5:0] OP_INC_A   = 6'h06;
    localparam logic [5:0] OP_SHL_A   = 6'h07;
    localparam logic [5:0] OP_SHR_A   = 6'h08;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]  state;
    logic [1:0]  cnt;
    logic        carry;
    logic        cadd_q;
    logic [3:0]  sum_q;
    logic [5:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] acc;
    logic [15:0] result_q;
    logic        cf_q;
    logic        zf_q;
    logic        illegal_q;

    logic [1:0]  pos;
    logic [3:0]  nib_val;
    logic        carry_nxt;
    logic        fix_needed;
    logic        last;
    logic        is_logic;
    logic [15:0] acc_nxt;

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_AND_A_B, OP_OR_A_B, OP_XOR_A_B, OP_NOT_A,
            OP_ADD_A_B, OP_INC_A, OP_SHL_A, OP_SHR_A: is_legal = 1'b1;
            default:                                  is_legal = 1'b0;
        endcase
    endfunction

    // SHR walks from the top nibble down; everything else walks upward.
    assign pos      = (op_q == OP_SHR_A) ? ~cnt : cnt;
    assign is_logic = (op_q == OP_AND_A_B) || (op_q == OP_OR_A_B) ||
                      (op_q == OP_XOR_A_B) || (op_q == OP_NOT_A);

    always_comb begin
        nib_val    = bus.alu_r;
        carry_nxt  = 1'b0;
        fix_needed = 1'b0;
        if (state == ST_EXEC) begin
            case (op_q)
                OP_ADD_A_B: begin
                    carry_nxt  = bus.alu_cf;
                    fix_needed = carry;
                end
                OP_INC_A: carry_nxt = bus.alu_cf;
                OP_SHL_A: begin
                    nib_val   = {bus.alu_r[3:1], carry};
                    carry_nxt = bus.alu_cf;
                end
                OP_SHR_A: begin
                    nib_val   = {carry, bus.alu_r[2:0]};
                    carry_nxt = bus.alu_cf;
                end
                default: carry_nxt = 1'b0;
            endcase
        end else if (state == ST_FIXUP) begin
            carry_nxt = cadd_q | bus.alu_cf;
        end
        acc_nxt                 = acc;
        acc_nxt[{pos, 2'b00} +: 4] = nib_val;
        // INC stops early once the carry chain dies; the rest of acc already holds A.
        last = (cnt == 2'd3) || ((op_q == OP_INC_A) && !carry_nxt);
    end

    always_comb begin
        bus.alu_opcode = OP_AND_A_B;
        bus.alu_a      = 4'h0;
        bus.alu_b      = 4'h0;
        if (state == ST_EXEC) begin
            bus.alu_opcode = op_q;
            bus.alu_a      = a_q[{pos, 2'b00} +: 4];
            bus.alu_b      = b_q[{pos, 2'b00} +: 4];
        end else if (state == ST_FIXUP) begin
            bus.alu_opcode = OP_INC_A;
            bus.alu_a      = sum_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 2'd0;
            carry     <= 1'b0;
            cadd_q    <= 1'b0;
            sum_q     <= 4'h0;
            op_q      <= OP_AND_A_B;
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            acc       <= 16'h0000;
            result_q  <= 16'h0000;
            cf_q      <= 1'b0;
            zf_q      <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        op_q      <= bus.opcode;
                        a_q       <= bus.a;
                        b_q       <= bus.b;
                        acc       <= bus.a;
                        cnt       <= 2'd0;
                        carry     <= 1'b0;
                        illegal_q <= !is_legal(bus.opcode);
                        if (is_legal(bus.opcode)) begin
                            state <= ST_EXEC;
                        end else begin
                            cf_q  <= 1'b0;
                            state <= ST_DONE;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_EXEC, ST_FIXUP: begin
                    if (fix_needed) begin
                        sum_q  <= bus.alu_r;
                        cadd_q <= bus.alu_cf;
                        state  <= ST_FIXUP;
                    end else begin
                        acc   <= acc_nxt;
                        carry <= carry_nxt;
                        if (last) begin
                            result_q <= acc_nxt;
                            cf_q     <= is_logic ? 1'b0 : carry_nxt;
                            zf_q     <= (acc_nxt == 16'h0000);
                            state    <= ST_DONE;
                        end else begin
                            cnt   <= cnt + 2'd1;
                            state <= ST_EXEC;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = (state == ST_EXEC) || (state == ST_FIXUP);
    assign bus.done    = (state == ST_DONE);
    assign bus.result  = result_q;
    assign bus.cf      = cf_q;
    assign bus.zf      = zf_q;
    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_nibble_seq_alu_ctrl.sv
// Directed bench for the nibble sequencer with a behavioural 4-bit ALU attached;
// expected values are hand-computed constants.
module tb_nibble_seq_alu_ctrl;

    localparam logic [5:0] OP_AND_A_B = 6'h01;
    localparam logic [5:0] OP_OR_A_B  = 6'h02;
    localparam logic [5:0] OP_XOR_A_B = 6'h03;
    localparam logic [5:0] OP_NOT_A   = 6'h04;
    localparam logic [5:0] OP_ADD_A_B = 6'h05;
    localparam logic [5:0] OP_INC_A   = 6'h06;
    localparam logic [5:0] OP_SHL_A   = 6'h07;
    localparam logic [5:0] OP_SHR_A   = 6'h08;
    localparam logic [5:0] OP_BAD     = 6'h3F;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   done_cycle;
    int   busy_cnt;
    int   extra_done;

    nibble_seq_alu_ctrl_if bus ();

    nibble_seq_alu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared 4-bit ALU, combinational.
    always_comb begin
        bus.alu_r  = 4'h0;
        bus.alu_cf = 1'b0;
        case (bus.alu_opcode)
            OP_AND_A_B: bus.alu_r = bus.alu_a & bus.alu_b;
            OP_OR_A_B:  bus.alu_r = bus.alu_a | bus.alu_b;
            OP_XOR_A_B: bus.alu_r = bus.alu_a ^ bus.alu_b;
            OP_NOT_A:   bus.alu_r = ~bus.alu_a;
            OP_ADD_A_B: {bus.alu_cf, bus.alu_r} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            OP_INC_A:   {bus.alu_cf, bus.alu_r} = {1'b0, bus.alu_a} + 5'd1;
            OP_SHL_A:   {bus.alu_cf, bus.alu_r} = {bus.alu_a, 1'b0};
            OP_SHR_A:   {bus.alu_r, bus.alu_cf} = {1'b0, bus.alu_a};
            default:    bus.alu_r = 4'h0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Starts one op, then follows it cycle by cycle until done or a 20-cycle bound.
    // glitch_cycle injects an extra start; reset_cycle pulses reset (0 disables).
    task automatic applyStimulus(input logic [5:0] op, input logic [15:0] av, input logic [15:0] bv,
                                 input int glitch_cycle, input int reset_cycle);
        int cycle;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.a      = av;
        bus.b      = bv;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        done_cycle = 0;
        busy_cnt   = 0;
        cycle      = 1;
        while (cycle <= 20 && done_cycle == 0) begin
            if (bus.done) begin
                done_cycle = cycle;
            end else begin
                if (bus.busy) busy_cnt++;
                if (cycle == glitch_cycle) begin
                    @(negedge clk);
                    bus.start  = 1'b1;
                    bus.opcode = OP_AND_A_B;
                    bus.a      = 16'hFFFF;
                    bus.b      = 16'h00FF;
                end
                if (cycle == reset_cycle) begin
                    @(negedge clk);
                    reset = 1'b1;
                end
                @(posedge clk);
                #1;
                bus.start = 1'b0;
                reset     = 1'b0;
                cycle++;
            end
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.opcode = OP_AND_A_B;
        bus.a      = 16'h0000;
        bus.b      = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_result", bus.result, 16'h0000);
        checkOutput("rst_cf", bus.cf, 0);
        checkOutput("rst_zf", bus.zf, 1);
        checkOutput("rst_illegal", bus.illegal, 0);
        checkOutput("rst_alu_op", bus.alu_opcode, OP_AND_A_B);
        checkOutput("rst_alu_a", bus.alu_a, 0);
        checkOutput("rst_alu_b", bus.alu_b, 0);

        applyStimulus(OP_AND_A_B, 16'hF0F0, 16'h3C3C, 0, 0);
        checkOutput("and_cycle", done_cycle, 5);
        checkOutput("and_busy", busy_cnt, 4);
        checkOutput("and_busy_at_done", bus.busy, 0);
        checkOutput("and_result", bus.result, 16'h3030);
        checkOutput("and_cf", bus.cf, 0);
        checkOutput("and_zf", bus.zf, 0);
        idleCycles(1);
        checkOutput("and_done_pulse", bus.done, 0);
        checkOutput("and_result_held", bus.result, 16'h3030);
        checkOutput("idle_alu_a", bus.alu_a, 0);
        checkOutput("idle_alu_op", bus.alu_opcode, OP_AND_A_B);

        applyStimulus(OP_OR_A_B, 16'hF0F0, 16'h0F00, 0, 0);
        checkOutput("or_result", bus.result, 16'hFFF0);
        idleCycles(2);
        applyStimulus(OP_XOR_A_B, 16'hAAAA, 16'hFFFF, 0, 0);
        checkOutput("xor_result", bus.result, 16'h5555);
        idleCycles(2);
        applyStimulus(OP_NOT_A, 16'h1234, 16'h0000, 0, 0);
        checkOutput("not_result", bus.result, 16'hEDCB);
        checkOutput("not_cycle", done_cycle, 5);
        idleCycles(2);

        applyStimulus(OP_ADD_A_B, 16'hFFFF, 16'h0001, 0, 0);
        checkOutput("add_ffff_cycle", done_cycle, 8);
        checkOutput("add_ffff_busy", busy_cnt, 7);
        checkOutput("add_ffff_result", bus.result, 16'h0000);
        checkOutput("add_ffff_cf", bus.cf, 1);
        checkOutput("add_ffff_zf", bus.zf, 1);
        idleCycles(2);

        applyStimulus(OP_ADD_A_B, 16'h1234, 16'h4321, 2, 0);
        checkOutput("add_nc_cycle", done_cycle, 5);
        checkOutput("add_nc_result", bus.result, 16'h5555);
        checkOutput("add_nc_cf", bus.cf, 0);
        checkOutput("add_nc_zf", bus.zf, 0);
        extra_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) extra_done++;
        end
        checkOutput("ignored_start", extra_done, 0);
        checkOutput("ignored_result", bus.result, 16'h5555);

        applyStimulus(OP_ADD_A_B, 16'h0FF8, 16'h0008, 0, 0);
        checkOutput("add_mid_cycle", done_cycle, 8);
        checkOutput("add_mid_result", bus.result, 16'h1000);
        checkOutput("add_mid_cf", bus.cf, 0);
        idleCycles(2);

        applyStimulus(OP_INC_A, 16'h1234, 16'h0000, 0, 0);
        checkOutput("inc_short_cycle", done_cycle, 2);
        checkOutput("inc_short_result", bus.result, 16'h1235);
        checkOutput("inc_short_cf", bus.cf, 0);
        idleCycles(2);
        applyStimulus(OP_INC_A, 16'hFFFF, 16'h0000, 0, 0);
        checkOutput("inc_wrap_cycle", done_cycle, 5);
        checkOutput("inc_wrap_result", bus.result, 16'h0000);
        checkOutput("inc_wrap_cf", bus.cf, 1);
        checkOutput("inc_wrap_zf", bus.zf, 1);
        idleCycles(2);

        applyStimulus(OP_SHL_A, 16'h8001, 16'h0000, 0, 0);
        checkOutput("shl_cycle", done_cycle, 5);
        checkOutput("shl_result", bus.result, 16'h0002);
        checkOutput("shl_cf", bus.cf, 1);
        idleCycles(2);
        applyStimulus(OP_SHL_A, 16'h0888, 16'h0000, 0, 0);
        checkOutput("shl_chain_result", bus.result, 16'h1110);
        checkOutput("shl_chain_cf", bus.cf, 0);
        idleCycles(2);
        applyStimulus(OP_SHR_A, 16'h1110, 16'h0000, 0, 0);
        checkOutput("shr_chain_result", bus.result, 16'h0888);
        idleCycles(2);
        applyStimulus(OP_SHR_A, 16'h8001, 16'h0000, 0, 0);
        checkOutput("shr_cycle", done_cycle, 5);
        checkOutput("shr_result", bus.result, 16'h4000);
        checkOutput("shr_cf", bus.cf, 1);
        idleCycles(2);

        applyStimulus(OP_BAD, 16'h1111, 16'h2222, 0, 0);
        checkOutput("ill_cycle", done_cycle, 1);
        checkOutput("ill_flag", bus.illegal, 1);
        checkOutput("ill_result", bus.result, 16'h4000);
        checkOutput("ill_cf", bus.cf, 0);
        checkOutput("ill_zf", bus.zf, 0);
        idleCycles(2);

        applyStimulus(OP_AND_A_B, 16'hF0F0, 16'h3C3C, 0, 0);
        checkOutput("b2b_first_result", bus.result, 16'h3030);
        checkOutput("b2b_illegal_clr", bus.illegal, 0);
        applyStimulus(OP_OR_A_B, 16'h000F, 16'h00F0, 0, 0);
        checkOutput("b2b_second_cycle", done_cycle, 5);
        checkOutput("b2b_second_result", bus.result, 16'h00FF);
        idleCycles(2);

        applyStimulus(OP_ADD_A_B, 16'hFFFF, 16'h0001, 0, 3);
        checkOutput("rst_mid_no_done", done_cycle, 0);
        checkOutput("rst_mid_result", bus.result, 16'h0000);
        checkOutput("rst_mid_zf", bus.zf, 1);
        checkOutput("rst_mid_busy", bus.busy, 0);
        checkOutput("rst_mid_alu_a", bus.alu_a, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
